// File: rtl/fetch_queue.sv
// fetch_queue: small instruction FIFO between fetch and decode.
// Holds {instr, pc2} pairs, absorbs decode stalls, drops wrong-path work on
// flush and stops accepting fetch once a HALT has been queued.
module fetch_queue #(
  parameter int          DEPTH     = 2,
  parameter int          PTR_W     = 1,
  parameter logic [15:0] NOP_INSTR = 16'h0800
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [15:0]      in_instr,
  input  logic [15:0]      in_pc2,
  input  logic             flush,
  input  logic             out_ready,
  output logic             in_ready,
  output logic             out_valid,
  output logic [15:0]      out_instr,
  output logic [15:0]      out_pc2,
  output logic [PTR_W:0]   count,
  output logic             halt_seen,
  output logic             err
);

  localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

  logic [31:0]      r_mem [DEPTH];
  logic [PTR_W-1:0] r_rd_ptr;
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W:0]   r_count;
  logic             r_halt_seen;

  logic             w_push;
  logic             w_pop;
  logic             w_is_halt;
  logic [31:0]      w_head;

  // Handshake qualifiers; flush wins over both directions.
  always_comb begin
    in_ready  = (r_count != FULL_CNT) & ~r_halt_seen;
    out_valid = (r_count != '0);
    w_push    = in_valid & in_ready & ~flush;
    w_pop     = out_valid & out_ready & ~flush;
    w_is_halt = (in_instr[15:11] == 5'b00000);
    err       = in_valid & ~in_ready & ~flush;
  end

  // Head entry presented to decode, or a NOP bubble when empty.
  always_comb begin
    w_head    = r_mem[r_rd_ptr];
    out_instr = NOP_INSTR;
    out_pc2   = 16'h0000;
    if (out_valid) begin
      out_instr = w_head[31:16];
      out_pc2   = w_head[15:0];
    end
  end

  // Storage array; contents are don't-care after reset so it has no reset.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= {in_instr, in_pc2};
  end

  // Pointers, occupancy and the sticky HALT flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rd_ptr    <= '0;
      r_wr_ptr    <= '0;
      r_count     <= '0;
      r_halt_seen <= 1'b0;
    end else if (flush) begin
      r_rd_ptr    <= '0;
      r_wr_ptr    <= '0;
      r_count     <= '0;
      r_halt_seen <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (PTR_W+1)'(1);
        2'b01:   r_count <= r_count - (PTR_W+1)'(1);
        default: r_count <= r_count;
      endcase
      if (w_push && w_is_halt) r_halt_seen <= 1'b1;
    end
  end

  assign count     = r_count;
  assign halt_seen = r_halt_seen;

endmodule

// File: tb/tb_fetch_queue.sv
// Bench for fetch_queue: directed vector table, async-reset check, then
// randomized traffic against a queue-based reference model.
module tb_fetch_queue;

  localparam int DEPTH = 2;
  localparam int PTR_W = 1;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic [15:0]      in_instr;
  logic [15:0]      in_pc2;
  logic             flush;
  logic             out_ready;
  logic             in_ready;
  logic             out_valid;
  logic [15:0]      out_instr;
  logic [15:0]      out_pc2;
  logic [PTR_W:0]   count;
  logic             halt_seen;
  logic             err;

  int n_cmp  = 0;
  int n_fail = 0;

  fetch_queue #(.DEPTH(DEPTH), .PTR_W(PTR_W), .NOP_INSTR(16'h0800)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_instr(in_instr),
    .in_pc2(in_pc2), .flush(flush), .out_ready(out_ready),
    .in_ready(in_ready), .out_valid(out_valid), .out_instr(out_instr),
    .out_pc2(out_pc2), .count(count), .halt_seen(halt_seen), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        iv;
    logic [15:0] instr;
    logic [15:0] pc2;
    logic        fl;
    logic        ordy;
    logic        e_ov;
    logic [15:0] e_instr;
    logic [15:0] e_pc2;
    int          e_cnt;
    logic        e_ir;
    logic        e_err;
    logic        e_halt;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(logic iv, logic [15:0] instr, logic [15:0] pc2,
                              logic fl, logic ordy, logic e_ov,
                              logic [15:0] e_instr, logic [15:0] e_pc2,
                              int e_cnt, logic e_ir, logic e_err, logic e_halt);
    vec_t v;
    v.iv = iv; v.instr = instr; v.pc2 = pc2; v.fl = fl; v.ordy = ordy;
    v.e_ov = e_ov; v.e_instr = e_instr; v.e_pc2 = e_pc2; v.e_cnt = e_cnt;
    v.e_ir = e_ir; v.e_err = e_err; v.e_halt = e_halt;
    return v;
  endfunction

  task automatic chk(string name, int idx, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s [%0d]: got %h expected %h", name, idx, act, exp);
    end
  endtask

  task automatic chk_all(int idx, logic e_ov, logic [15:0] e_instr,
                         logic [15:0] e_pc2, int e_cnt, logic e_ir,
                         logic e_err, logic e_halt);
    chk("out_valid", idx, 32'(out_valid), 32'(e_ov));
    chk("out_instr", idx, 32'(out_instr), 32'(e_instr));
    chk("out_pc2",   idx, 32'(out_pc2),   32'(e_pc2));
    chk("count",     idx, 32'(count),     32'(e_cnt));
    chk("in_ready",  idx, 32'(in_ready),  32'(e_ir));
    chk("err",       idx, 32'(err),       32'(e_err));
    chk("halt_seen", idx, 32'(halt_seen), 32'(e_halt));
  endtask

  task automatic drive(logic iv, logic [15:0] instr, logic [15:0] pc2,
                       logic fl, logic ordy);
    in_valid = iv; in_instr = instr; in_pc2 = pc2; flush = fl; out_ready = ordy;
  endtask

  // reference model state
  logic [31:0] mq[$];
  logic        m_halt;

  initial begin
    rst = 1'b1;
    drive(0, 16'h0, 16'h0, 0, 0);

    // directed sequence: each row is inputs for one cycle and the outputs
    // expected before that cycle's rising edge
    //             iv instr     pc2      fl or  ov instr     pc2     cnt ir err halt
    tbl.push_back(mk(1, 16'h4001, 16'h0002, 0, 0, 0, 16'h0800, 16'h0000, 0, 1, 0, 0));
    tbl.push_back(mk(1, 16'h4002, 16'h0004, 0, 0, 1, 16'h4001, 16'h0002, 1, 1, 0, 0));
    tbl.push_back(mk(0, 16'h0000, 16'h0000, 0, 0, 1, 16'h4001, 16'h0002, 2, 0, 0, 0));
    tbl.push_back(mk(1, 16'h4003, 16'h0006, 0, 1, 1, 16'h4001, 16'h0002, 2, 0, 1, 0));
    tbl.push_back(mk(0, 16'h0000, 16'h0000, 0, 1, 1, 16'h4002, 16'h0004, 1, 1, 0, 0));
    tbl.push_back(mk(0, 16'h0000, 16'h0000, 0, 0, 0, 16'h0800, 16'h0000, 0, 1, 0, 0));
    // streaming with simultaneous push/pop at count=1
    tbl.push_back(mk(1, 16'h5000, 16'h0010, 0, 1, 0, 16'h0800, 16'h0000, 0, 1, 0, 0));
    tbl.push_back(mk(1, 16'h5001, 16'h0012, 0, 1, 1, 16'h5000, 16'h0010, 1, 1, 0, 0));
    tbl.push_back(mk(1, 16'h5002, 16'h0014, 0, 1, 1, 16'h5001, 16'h0012, 1, 1, 0, 0));
    tbl.push_back(mk(1, 16'h5003, 16'h0016, 0, 1, 1, 16'h5002, 16'h0014, 1, 1, 0, 0));
    tbl.push_back(mk(0, 16'h0000, 16'h0000, 0, 1, 1, 16'h5003, 16'h0016, 1, 1, 0, 0));
    // fill, then flush with an incoming push that must be dropped
    tbl.push_back(mk(1, 16'h6000, 16'h0020, 0, 0, 0, 16'h0800, 16'h0000, 0, 1, 0, 0));
    tbl.push_back(mk(1, 16'h6001, 16'h0022, 0, 0, 1, 16'h6000, 16'h0020, 1, 1, 0, 0));
    tbl.push_back(mk(1, 16'h6002, 16'h0024, 1, 0, 1, 16'h6000, 16'h0020, 2, 0, 0, 0));
    tbl.push_back(mk(0, 16'h0000, 16'h0000, 0, 0, 0, 16'h0800, 16'h0000, 0, 1, 0, 0));
    // HALT blocks further pushes, drains, cleared by flush
    tbl.push_back(mk(1, 16'h0000, 16'h0030, 0, 0, 0, 16'h0800, 16'h0000, 0, 1, 0, 0));
    tbl.push_back(mk(1, 16'h4003, 16'h0032, 0, 0, 1, 16'h0000, 16'h0030, 1, 0, 1, 1));
    tbl.push_back(mk(0, 16'h0000, 16'h0000, 0, 1, 1, 16'h0000, 16'h0030, 1, 0, 0, 1));
    tbl.push_back(mk(0, 16'h0000, 16'h0000, 0, 0, 0, 16'h0800, 16'h0000, 0, 0, 0, 1));
    tbl.push_back(mk(0, 16'h0000, 16'h0000, 1, 0, 0, 16'h0800, 16'h0000, 0, 0, 0, 1));
    tbl.push_back(mk(0, 16'h0000, 16'h0000, 0, 0, 0, 16'h0800, 16'h0000, 0, 1, 0, 0));

    @(negedge clk);
    #1;
    chk_all(-1, 0, 16'h0800, 16'h0000, 0, 1, 0, 0);
    @(negedge clk);
    rst = 1'b0;

    foreach (tbl[i]) begin
      if (i != 0) @(negedge clk);
      drive(tbl[i].iv, tbl[i].instr, tbl[i].pc2, tbl[i].fl, tbl[i].ordy);
      #1;
      chk_all(i, tbl[i].e_ov, tbl[i].e_instr, tbl[i].e_pc2, tbl[i].e_cnt,
              tbl[i].e_ir, tbl[i].e_err, tbl[i].e_halt);
    end

    // asynchronous reset with two entries queued
    @(negedge clk); drive(1, 16'h7001, 16'h0040, 0, 0);
    @(negedge clk); drive(1, 16'h7002, 16'h0042, 0, 0);
    @(negedge clk); drive(0, 16'h0000, 16'h0000, 0, 0);
    #1;
    chk("pre_rst_count", 100, 32'(count), 32'd2);
    chk("pre_rst_instr", 100, 32'(out_instr), 32'h7001);
    #2;
    rst = 1'b1;
    in_valid = 1'b1;
    #1;
    chk_all(101, 0, 16'h0800, 16'h0000, 0, 1, 0, 0);
    @(negedge clk);
    rst = 1'b0;
    in_valid = 1'b0;

    // randomized traffic against a queue model
    mq.delete();
    m_halt = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      logic        m_ready, iv, fl, ordy, do_pop, do_push;
      logic [15:0] ins, pc;
      @(negedge clk);
      m_ready = (mq.size() < DEPTH) && !m_halt;
      iv   = ($urandom_range(0, 9) < 7);
      if (!m_ready && $urandom_range(0, 3) != 0) iv = 1'b0;
      fl   = ($urandom_range(0, 19) == 0);
      ordy = ($urandom_range(0, 9) < 6);
      ins  = 16'($urandom);
      if ($urandom_range(0, 39) == 0) ins[15:11] = 5'b00000;
      else if (ins[15:11] == 5'b00000) ins[15:11] = 5'b00001;
      pc   = 16'($urandom);
      drive(iv, ins, pc, fl, ordy);
      #1;
      if (mq.size() > 0)
        chk_all(1000 + c, 1, mq[0][31:16], mq[0][15:0], mq.size(), m_ready,
                iv && !m_ready && !fl, m_halt);
      else
        chk_all(1000 + c, 0, 16'h0800, 16'h0000, 0, m_ready,
                iv && !m_ready && !fl, m_halt);
      if (fl) begin
        mq.delete();
        m_halt = 1'b0;
      end else begin
        do_pop  = (mq.size() > 0) && ordy;
        do_push = iv && m_ready;
        if (do_pop) void'(mq.pop_front());
        if (do_push) begin
          mq.push_back({ins, pc});
          if (ins[15:11] == 5'b00000) m_halt = 1'b1;
        end
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
